// File: rtl/rad_sync_fifo.sv
// Single-clock FIFO for any DEPTH >= 2 with fill count, live almost-full/empty
// thresholds, overflow/underflow pulses and a selectable standard/FWFT read port.
module rad_sync_fifo #(
  parameter int DSIZE = 8,
  parameter int DEPTH = 8,
  parameter bit FWFT  = 1'b0,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic [CW-1:0]    af_thresh,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  input  logic [CW-1:0]    ae_thresh,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_waddr;
  logic [AW-1:0]    r_raddr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_wfull;
  logic w_rempty;
  logic w_wacc;
  logic w_racc;

  // Acceptance looks only at the registered flags, so a full FIFO rejects a
  // write even when a read frees a slot at the same edge (and vice versa).
  assign w_wfull  = (r_count == FULL_COUNT);
  assign w_rempty = (r_count == '0);
  assign w_wacc   = winc && !w_wfull;
  assign w_racc   = rinc && !w_rempty;

  assign wfull         = w_wfull;
  assign rempty        = w_rempty;
  assign walmost_full  = (r_count >= af_thresh);
  assign ralmost_empty = (r_count <= ae_thresh);
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

  always_ff @(posedge clk) begin
    if (!rst && w_wacc) begin
      r_mem[r_waddr] <= wdata;
    end
  end

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths never alias.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= winc && w_wfull;
      r_underflow <= rinc && w_rempty;
      if (w_wacc) begin
        r_waddr <= (r_waddr == LAST_ADDR) ? '0 : r_waddr + AW'(1);
      end
      if (w_racc) begin
        r_raddr <= (r_raddr == LAST_ADDR) ? '0 : r_raddr + AW'(1);
      end
      case ({w_wacc, w_racc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata = w_rempty ? '0 : r_mem[r_raddr];
    end else begin : g_std
      logic [DSIZE-1:0] r_rdata;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rdata <= '0;
        end else if (w_racc) begin
          r_rdata <= r_mem[r_raddr];
        end
      end

      assign rdata = r_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_rad_sync_fifo.sv
// Bench for rad_sync_fifo: standard and FWFT instances (DEPTH=5) driven in
// lockstep and compared against a queue model, a directed table and random traffic.
module tb_rad_sync_fifo;

  localparam int DEPTH = 5;
  localparam int DSIZE = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             winc;
  logic             rinc;
  logic [DSIZE-1:0] wdata;
  logic [CW-1:0]    afThresh;
  logic [CW-1:0]    aeThresh;

  logic [DSIZE-1:0] stdRdata, fwftRdata;
  logic [CW-1:0]    stdCount, fwftCount;
  logic             stdWfull, fwftWfull;
  logic             stdRempty, fwftRempty;
  logic             stdWaf, fwftWaf;
  logic             stdRae, fwftRae;
  logic             stdOvf, fwftOvf;
  logic             stdUnf, fwftUnf;

  int checkCount = 0;
  int passCount  = 0;

  logic [DSIZE-1:0] modelQ[$];
  logic [DSIZE-1:0] expStd;
  logic             expOvf;
  logic             expUnf;

  typedef struct {
    bit         rst;
    bit         winc;
    logic [7:0] wdata;
    bit         rinc;
    int         expCount;
    bit         expOvf;
    bit         expUnf;
    logic [7:0] expStd;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  rad_sync_fifo #(.DSIZE(DSIZE), .DEPTH(DEPTH), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(stdWfull),
    .walmost_full(stdWaf), .af_thresh(afThresh), .rinc(rinc), .rdata(stdRdata),
    .rempty(stdRempty), .ralmost_empty(stdRae), .ae_thresh(aeThresh),
    .count(stdCount), .overflow(stdOvf), .underflow(stdUnf)
  );

  rad_sync_fifo #(.DSIZE(DSIZE), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(fwftWfull),
    .walmost_full(fwftWaf), .af_thresh(afThresh), .rinc(rinc), .rdata(fwftRdata),
    .rempty(fwftRempty), .ralmost_empty(fwftRae), .ae_thresh(aeThresh),
    .count(fwftCount), .overflow(fwftOvf), .underflow(fwftUnf)
  );

  task automatic checkVal(input string name, input logic [31:0] actual,
                          input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // Everything expected here comes from the queue contents and the thresholds.
  task automatic checkOutput();
    int n;
    n = modelQ.size();
    checkVal("stdCount", 32'(stdCount), n);
    checkVal("stdRempty", 32'(stdRempty), 32'(n == 0));
    checkVal("stdWfull", 32'(stdWfull), 32'(n == DEPTH));
    checkVal("stdWaf", 32'(stdWaf), 32'(n >= int'(afThresh)));
    checkVal("stdRae", 32'(stdRae), 32'(n <= int'(aeThresh)));
    checkVal("stdOvf", 32'(stdOvf), 32'(expOvf));
    checkVal("stdUnf", 32'(stdUnf), 32'(expUnf));
    checkVal("stdRdata", 32'(stdRdata), 32'(expStd));
    checkVal("fwftCount", 32'(fwftCount), n);
    checkVal("fwftFlags", {28'd0, fwftRempty, fwftWfull, fwftWaf, fwftRae},
             {28'd0, stdRempty, stdWfull, stdWaf, stdRae});
    checkVal("fwftErr", {30'd0, fwftOvf, fwftUnf}, {30'd0, expOvf, expUnf});
    checkVal("fwftRdata", 32'(fwftRdata), (n == 0) ? 32'd0 : 32'(modelQ[0]));
  endtask

  task automatic applyStimulus(input bit r, input bit w, input logic [7:0] d, input bit rd);
    bit full;
    bit empty;
    rst   = r;
    winc  = w;
    wdata = d;
    rinc  = rd;
    @(posedge clk);
    if (r) begin
      modelQ.delete();
      expOvf = 1'b0;
      expUnf = 1'b0;
      expStd = '0;
    end else begin
      full   = (modelQ.size() == DEPTH);
      empty  = (modelQ.size() == 0);
      expOvf = w && full;
      expUnf = rd && empty;
      if (rd && !empty) expStd = modelQ.pop_front();
      if (w && !full) modelQ.push_back(d);
    end
    #1;
    checkOutput();
  endtask

  function automatic void addRow(input bit r, input bit w, input logic [7:0] d, input bit rd,
                                 input int cnt, input bit ovf, input bit unf,
                                 input logic [7:0] std);
    vec_t v;
    v.rst = r; v.winc = w; v.wdata = d; v.rinc = rd;
    v.expCount = cnt; v.expOvf = ovf; v.expUnf = unf; v.expStd = std;
    vecs.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;
    afThresh = CW'(4); aeThresh = CW'(1);
    expOvf = 1'b0; expUnf = 1'b0; expStd = '0;

    // Fill, overflow, drain, underflow, wrap-around and simultaneous traffic.
    addRow(1, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) addRow(0, 1, 8'(8'h10 + i), 0, i + 1, 0, 0, 8'h00);
    addRow(0, 1, 8'h99, 0, 5, 1, 0, 8'h00);
    addRow(0, 0, 8'h00, 0, 5, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) addRow(0, 0, 8'h00, 1, 4 - i, 0, 0, 8'(8'h10 + i));
    addRow(0, 0, 8'h00, 1, 0, 0, 1, 8'h14);
    addRow(0, 0, 8'h00, 0, 0, 0, 0, 8'h14);
    for (int i = 0; i < 3; i++) addRow(0, 1, 8'(8'h20 + i), 0, i + 1, 0, 0, 8'h14);
    for (int i = 0; i < 3; i++) addRow(0, 0, 8'h00, 1, 2 - i, 0, 0, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++) addRow(0, 1, 8'(8'hA0 + i), 0, i + 1, 0, 0, 8'h22);
    for (int i = 0; i < 4; i++) addRow(0, 0, 8'h00, 1, 3 - i, 0, 0, 8'(8'hA0 + i));
    addRow(0, 1, 8'h30, 0, 1, 0, 0, 8'hA3);
    addRow(0, 1, 8'h31, 0, 2, 0, 0, 8'hA3);
    for (int i = 0; i < 10; i++) addRow(0, 1, 8'(8'h32 + i), 1, 2, 0, 0, 8'(8'h30 + i));
    for (int i = 0; i < 3; i++) addRow(0, 1, 8'(8'h3C + i), 0, 3 + i, 0, 0, 8'h39);
    addRow(0, 1, 8'h77, 1, 4, 1, 0, 8'h3A);
    for (int i = 0; i < 4; i++) addRow(0, 0, 8'h00, 1, 3 - i, 0, 0, 8'(8'h3B + i));
    addRow(0, 1, 8'h88, 1, 1, 0, 1, 8'h3E);
    addRow(0, 0, 8'h00, 1, 0, 0, 0, 8'h88);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].winc, vecs[k].wdata, vecs[k].rinc);
      checkVal("tblCount", 32'(stdCount), vecs[k].expCount);
      checkVal("tblOvf", 32'(stdOvf), 32'(vecs[k].expOvf));
      checkVal("tblUnf", 32'(stdUnf), 32'(vecs[k].expUnf));
      checkVal("tblRdata", 32'(stdRdata), 32'(vecs[k].expStd));
    end

    // Thresholds: af=4, ae=1 while stepping the count 0..5.
    applyStimulus(1, 0, 8'h00, 0);
    checkVal("thrAe0", 32'(stdRae), 32'd1);
    checkVal("thrAf0", 32'(stdWaf), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(0, 1, 8'(8'h40 + c), 0);
      checkVal("thrAe", 32'(stdRae), 32'(c <= 1));
      checkVal("thrAf", 32'(stdWaf), 32'(c >= 4));
    end
    aeThresh = CW'(7);
    #1;
    checkVal("aeAboveDepth", 32'(stdRae), 32'd1);
    aeThresh = CW'(1);
    applyStimulus(1, 0, 8'h00, 0);
    afThresh = CW'(0);
    #1;
    checkVal("afZero", 32'(stdWaf), 32'd1);
    afThresh = CW'(4);
    for (int c = 0; c < 3; c++) applyStimulus(0, 1, 8'(8'h50 + c), 0);
    checkVal("afBefore", 32'(stdWaf), 32'd0);
    afThresh = CW'(2);
    #1;
    checkVal("afLive", 32'(stdWaf), 32'd1);
    afThresh = CW'(4);

    // FWFT fall-through and reset in the middle of operation.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h55, 0);
    checkVal("fwftFall", 32'(fwftRdata), 32'h55);
    applyStimulus(0, 1, 8'h56, 0);
    applyStimulus(0, 1, 8'h57, 0);
    checkVal("preRstCount", 32'(fwftCount), 32'd3);
    applyStimulus(1, 1, 8'hEE, 0);
    checkVal("rstCount", 32'(fwftCount), 32'd0);
    checkVal("rstEmpty", 32'(fwftRempty), 32'd1);
    checkVal("rstFwftRdata", 32'(fwftRdata), 32'd0);
    applyStimulus(0, 0, 8'h00, 0);
    checkVal("rstWriteIgnored", 32'(fwftCount), 32'd0);

    // Random traffic with occasional resets and threshold changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        afThresh = CW'($urandom_range(0, 7));
        aeThresh = CW'($urandom_range(0, 7));
      end
      applyStimulus($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
                    8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
